// File: rtl/io_hub_pkg.sv
// Shared helpers for io_hub: counter/address widths, flattened-bus slicing and sticky flag update.
package io_hub_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // A single channel still needs a 1-bit address port.
  function automatic int unsigned addr_w(input int unsigned nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned chan, input int unsigned width);
    return chan * width;
  endfunction

  // Sticky flag next value: a set on the same edge beats a clear.
  function automatic logic flag_next(input logic q, input logic set, input logic clr);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module io_fifo import io_hub_pkg::*; #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [W-1:0]              data_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic [W-1:0]              head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/io_hub.sv
// Buffered multi-channel I/O hub between core strobes and external valid/ready channels.
// Optional FIFO-level interrupt built when IO_HUB_ITR_EN is defined.
module io_hub import io_hub_pkg::*; #(
  parameter int unsigned NUBITS = 16,
  parameter int unsigned NUIOIN = 2,
  parameter int unsigned NUIOOU = 2,
  parameter int unsigned FDEPTH = 4,
  parameter int unsigned ITRTHR = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_in,
  input  logic [addr_w(NUIOIN)-1:0]   addr_in,
  output logic [NUBITS-1:0]           io_in,
  input  logic                        out_en,
  input  logic [addr_w(NUIOOU)-1:0]   addr_out,
  input  logic [NUBITS-1:0]           io_out,
  output logic                        itr,
  input  logic [NUIOIN*NUBITS-1:0]    ext_in_data,
  input  logic [NUIOIN-1:0]           ext_in_valid,
  output logic [NUIOIN-1:0]           ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]    ext_out_data,
  output logic [NUIOOU-1:0]           ext_out_valid,
  input  logic [NUIOOU-1:0]           ext_out_ready,
  output logic [NUIOIN-1:0]           udf,
  output logic [NUIOOU-1:0]           ovf,
  input  logic                        clr_flags
);

  localparam int unsigned CW  = cnt_w(FDEPTH);
  localparam int unsigned AIW = addr_w(NUIOIN);
  localparam int unsigned AOW = addr_w(NUIOOU);

  if (ITRTHR < 1 || ITRTHR > FDEPTH) begin : g_bad_thr
    $error("io_hub: ITRTHR must be within 1..FDEPTH");
  end

  logic [NUIOIN-1:0]             in_full, in_empty, in_push, in_pop, in_rdy, udf_set, udf_d, udf_q;
  logic [NUIOIN-1:0][NUBITS-1:0] in_head, hold_q;
  logic [NUIOIN-1:0][CW-1:0]     in_cnt;
  logic [NUIOOU-1:0]             out_full, out_empty, out_push, out_pop, ovf_set, ovf_d, ovf_q;
  logic [NUIOOU-1:0][NUBITS-1:0] out_head;
  logic [NUIOOU-1:0][CW-1:0]     out_cnt;

  for (genvar c = 0; c < NUIOIN; c++) begin : g_in
    io_fifo #(.W(NUBITS), .DEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (in_push[c]),
      .pop_i   (in_pop[c]),
      .data_i  (ext_in_data[slice_lo(c, NUBITS) +: NUBITS]),
      .full_o  (in_full[c]),
      .empty_o (in_empty[c]),
      .count_o (in_cnt[c]),
      .head_o  (in_head[c])
    );
  end

  for (genvar c = 0; c < NUIOOU; c++) begin : g_out
    io_fifo #(.W(NUBITS), .DEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (out_push[c]),
      .pop_i   (out_pop[c]),
      .data_i  (io_out),
      .full_o  (out_full[c]),
      .empty_o (out_empty[c]),
      .count_o (out_cnt[c]),
      .head_o  (out_head[c])
    );
    assign ext_out_data[slice_lo(c, NUBITS) +: NUBITS] = out_head[c];
  end

  // Input side: ready held low in reset; core reads pop or flag underflow.
  always_comb begin
    in_rdy  = '0;
    in_push = '0;
    in_pop  = '0;
    udf_set = '0;
    udf_d   = '0;
    io_in   = '0;
    for (int c = 0; c < NUIOIN; c++) begin
      in_rdy[c]  = rst & ~in_full[c];
      in_push[c] = ext_in_valid[c] & in_rdy[c];
      if (req_in && (addr_in == AIW'(c))) begin
        in_pop[c]  = ~in_empty[c];
        udf_set[c] = in_empty[c];
      end
      if (addr_in == AIW'(c)) io_in = in_empty[c] ? hold_q[c] : in_head[c];
      udf_d[c] = flag_next(udf_q[c], udf_set[c], clr_flags);
    end
  end

  // Output side: a write to a full FIFO is still taken when the consumer pops that edge.
  always_comb begin
    out_pop  = '0;
    out_push = '0;
    ovf_set  = '0;
    ovf_d    = '0;
    for (int c = 0; c < NUIOOU; c++) begin
      out_pop[c] = ~out_empty[c] & ext_out_ready[c];
      if (out_en && (addr_out == AOW'(c))) begin
        out_push[c] = ~out_full[c] | out_pop[c];
        ovf_set[c]  = out_full[c] & ~out_pop[c];
      end
      ovf_d[c] = flag_next(ovf_q[c], ovf_set[c], clr_flags);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      udf_q  <= '0;
      ovf_q  <= '0;
    end else begin
      for (int c = 0; c < NUIOIN; c++) begin
        if (in_pop[c]) hold_q[c] <= in_head[c];
      end
      udf_q <= udf_d;
      ovf_q <= ovf_d;
    end
  end

  assign ext_in_ready  = in_rdy;
  assign ext_out_valid = ~out_empty;
  assign udf           = udf_q;
  assign ovf           = ovf_q;

`ifdef IO_HUB_ITR_EN
  logic [NUIOIN-1:0] thr_hit;
  logic              itr_q;
  logic              unused_c;

  always_comb begin
    thr_hit = '0;
    for (int c = 0; c < NUIOIN; c++) thr_hit[c] = (in_cnt[c] >= CW'(ITRTHR));
  end

  // Samples the current counts, so itr trails the threshold word by one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) itr_q <= 1'b0;
    else      itr_q <= |thr_hit;
  end

  assign itr      = itr_q;
  assign unused_c = ^{out_cnt, out_full};
`else
  logic unused_c;

  assign itr      = 1'b0;
  assign unused_c = ^{in_cnt, out_cnt, out_full};
`endif

endmodule

// File: tb/tb_io_hub.sv
// Directed self-checking bench for io_hub (default parameters); itr expectations follow IO_HUB_ITR_EN.
module tb_io_hub;

  localparam int unsigned NUBITS = 16;
  localparam int unsigned NUIOIN = 2;
  localparam int unsigned NUIOOU = 2;
`ifdef IO_HUB_ITR_EN
  localparam logic ITR_ON = 1'b1;
`else
  localparam logic ITR_ON = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       req_in = 1'b0;
  logic [0:0]                 addr_in = '0;
  logic [NUBITS-1:0]          io_in;
  logic                       out_en = 1'b0;
  logic [0:0]                 addr_out = '0;
  logic [NUBITS-1:0]          io_out = '0;
  logic                       itr;
  logic [NUIOIN*NUBITS-1:0]   ext_in_data = '0;
  logic [NUIOIN-1:0]          ext_in_valid = '0;
  logic [NUIOIN-1:0]          ext_in_ready;
  logic [NUIOOU*NUBITS-1:0]   ext_out_data;
  logic [NUIOOU-1:0]          ext_out_valid;
  logic [NUIOOU-1:0]          ext_out_ready = '0;
  logic [NUIOIN-1:0]          udf;
  logic [NUIOOU-1:0]          ovf;
  logic                       clr_flags = 1'b0;

  int checks = 0;
  int errors = 0;

  io_hub #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(4), .ITRTHR(1)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .req_in        (req_in),
    .addr_in       (addr_in),
    .io_in         (io_in),
    .out_en        (out_en),
    .addr_out      (addr_out),
    .io_out        (io_out),
    .itr           (itr),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .udf           (udf),
    .ovf           (ovf),
    .clr_flags     (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input int c, input logic [NUBITS-1:0] d);
    ext_in_data[c*NUBITS +: NUBITS] = d;
    ext_in_valid[c] = 1'b1;
    tick();
    ext_in_valid[c] = 1'b0;
  endtask

  task automatic read_in(input int c);
    addr_in = 1'(c);
    req_in  = 1'b1;
    tick();
    req_in  = 1'b0;
  endtask

  task automatic write_out(input int c, input logic [NUBITS-1:0] d);
    addr_out = 1'(c);
    io_out   = d;
    out_en   = 1'b1;
    tick();
    out_en   = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ext_in_ready !== 2'b00) begin errors++; $display("FAIL reset_in_ready: got %b want 00", ext_in_ready); end
    checks++; if (ext_out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b want 00", ext_out_valid); end
    checks++; if (io_in !== 16'h0000) begin errors++; $display("FAIL reset_io_in: got %h want 0000", io_in); end
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL reset_itr: got %b want 0", itr); end
    checks++; if ({udf, ovf} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {udf, ovf}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ext_in_ready !== 2'b11) begin errors++; $display("FAIL release_in_ready: got %b want 11", ext_in_ready); end
    tick();
  endtask

  task automatic test_push_read();
    push_in(1, 16'h1234);
    addr_in = 1'b1;
    #1;
    checks++; if (io_in !== 16'h1234) begin errors++; $display("FAIL push_io_in: got %h want 1234", io_in); end
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL push_itr_early: got %b want 0", itr); end
    tick();
    checks++; if (itr !== ITR_ON) begin errors++; $display("FAIL push_itr: got %b want %b", itr, ITR_ON); end
    read_in(1);
    #1;
    checks++; if (io_in !== 16'h1234) begin errors++; $display("FAIL read_hold: got %h want 1234", io_in); end
    tick();
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL itr_drop: got %b want 0", itr); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      ext_in_data[15:0] = 16'h00A0 + 16'(i);
      ext_in_valid[0]   = 1'b1;
      tick();
    end
    ext_in_valid[0] = 1'b0;
    #1;
    checks++; if (ext_in_ready !== 2'b10) begin errors++; $display("FAIL fill_ready: got %b want 10", ext_in_ready); end
    checks++; if (itr !== ITR_ON) begin errors++; $display("FAIL fill_itr: got %b want %b", itr, ITR_ON); end
    push_in(0, 16'h00FF);
    read_in(0);
    addr_in = 1'b0;
    #1;
    checks++; if (ext_in_ready[0] !== 1'b1) begin errors++; $display("FAIL pop_ready: got %b want 1", ext_in_ready[0]); end
    checks++; if (io_in !== 16'h00A1) begin errors++; $display("FAIL pop_head: got %h want 00a1", io_in); end
    read_in(0);
    read_in(0);
    checks++; if (io_in !== 16'h00A3) begin errors++; $display("FAIL last_head: got %h want 00a3", io_in); end
    read_in(0);
    checks++; if (io_in !== 16'h00A3) begin errors++; $display("FAIL drained_hold: got %h want 00a3", io_in); end
    checks++; if (udf !== 2'b00) begin errors++; $display("FAIL drained_udf: got %b want 00", udf); end
  endtask

  task automatic test_udf();
    push_in(0, 16'h00AA);
    read_in(0);
    read_in(0);
    checks++; if (io_in !== 16'h00AA) begin errors++; $display("FAIL udf_io_in: got %h want 00aa", io_in); end
    checks++; if (udf !== 2'b01) begin errors++; $display("FAIL udf_set: got %b want 01", udf); end
    clr_flags = 1'b1;
    read_in(0);
    clr_flags = 1'b0;
    checks++; if (udf !== 2'b01) begin errors++; $display("FAIL udf_set_wins: got %b want 01", udf); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if (udf !== 2'b00) begin errors++; $display("FAIL udf_clear: got %b want 00", udf); end
  endtask

  task automatic test_ovf();
    logic [NUBITS-1:0] exp_q [4];
    exp_q = '{16'h5001, 16'h5002, 16'h5003, 16'h5555};
    ext_out_ready = 2'b00;
    write_out(1, 16'h5000);
    checks++; if (ext_out_valid !== 2'b10) begin errors++; $display("FAIL out_valid: got %b want 10", ext_out_valid); end
    checks++; if (ext_out_data[31:16] !== 16'h5000) begin errors++; $display("FAIL out_head: got %h want 5000", ext_out_data[31:16]); end
    for (int i = 1; i < 4; i++) write_out(1, 16'h5000 + 16'(i));
    write_out(1, 16'h5555);
    checks++; if (ovf !== 2'b10) begin errors++; $display("FAIL ovf_set: got %b want 10", ovf); end
    checks++; if (ext_out_data[31:16] !== 16'h5000) begin errors++; $display("FAIL ovf_head: got %h want 5000", ext_out_data[31:16]); end
    ext_out_ready[1] = 1'b1;
    write_out(1, 16'h5555);
    ext_out_ready[1] = 1'b0;
    #1;
    checks++; if (ext_out_data[31:16] !== 16'h5001) begin errors++; $display("FAIL bypass_head: got %h want 5001", ext_out_data[31:16]); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL ovf_clear: got %b want 00", ovf); end
    ext_out_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ext_out_valid[1] !== 1'b1 || ext_out_data[31:16] !== exp_q[i]) begin
        errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, ext_out_valid[1], ext_out_data[31:16], exp_q[i]);
      end
      tick();
    end
    ext_out_ready[1] = 1'b0;
    checks++; if (ext_out_valid !== 2'b00) begin errors++; $display("FAIL drain_empty: got %b want 00", ext_out_valid); end
  endtask

  task automatic test_back_to_back();
    addr_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_in_data[31:16] = 16'h00B0 + 16'(i);
      ext_in_valid[1]    = 1'b1;
      req_in             = (i > 0);
      addr_out           = 1'b0;
      io_out             = 16'h00C0 + 16'(i);
      out_en             = 1'b1;
      ext_out_ready[0]   = (i > 0);
      tick();
      checks++;
      if (io_in !== 16'h00B0 + 16'(i) || ext_out_data[15:0] !== 16'h00C0 + 16'(i) || ext_out_valid[0] !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d: got in=%h out=%h v=%b want in=%h out=%h v=1",
                           i, io_in, ext_out_data[15:0], ext_out_valid[0], 16'h00B0 + 16'(i), 16'h00C0 + 16'(i));
      end
    end
    ext_in_valid[1]  = 1'b0;
    out_en           = 1'b0;
    req_in           = 1'b1;
    ext_out_ready[0] = 1'b1;
    tick();
    req_in           = 1'b0;
    ext_out_ready[0] = 1'b0;
    #1;
    checks++; if (io_in !== 16'h00B3 || ext_out_valid !== 2'b00) begin
      errors++; $display("FAIL b2b_end: got in=%h v=%b want in=00b3 v=00", io_in, ext_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        ext_in_data  = {16'h00E0 + 16'(i), 16'h00D0 + 16'(i)};
        ext_in_valid = 2'b11;
      end else begin
        ext_in_valid = 2'b00;
      end
      addr_out = 1'(i % 2);
      io_out   = 16'h00F0 + 16'(i);
      out_en   = 1'b1;
      tick();
    end
    out_en       = 1'b0;
    ext_in_valid = 2'b00;
    addr_in      = 1'b0;
    #1;
    checks++; if (ext_out_valid !== 2'b11 || ext_in_ready !== 2'b11 || io_in !== 16'h00D0) begin
      errors++; $display("FAIL pre_reset: got v=%b r=%b in=%h want v=11 r=11 in=00d0", ext_out_valid, ext_in_ready, io_in);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ext_out_valid !== 2'b00 || io_in !== 16'h0000 || ext_in_ready !== 2'b00) begin
      errors++; $display("FAIL mid_reset: got v=%b in=%h r=%b want v=00 in=0000 r=00", ext_out_valid, io_in, ext_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    addr_in = 1'b1;
    #1;
    checks++; if (ext_out_valid !== 2'b00 || io_in !== 16'h0000 || itr !== 1'b0) begin
      errors++; $display("FAIL post_reset: got v=%b in=%h itr=%b want v=00 in=0000 itr=0", ext_out_valid, io_in, itr);
    end
    read_in(0);
    read_in(1);
    checks++; if (udf !== 2'b11) begin errors++; $display("FAIL post_reset_empty: got udf=%b want 11", udf); end
  endtask

  initial begin
    test_reset();
    test_push_read();
    test_fill();
    test_udf();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
